unpack_sig_sched: RTL and testbench
===================================

// Module: unpack_sig_sched
// PURPOSE
//  Sequences one shared significand-unpack unit (sig normalise + leading-zero count) across both operands of an FP op.
//  Accepts an operand pair, issues A then B to the shared unit, captures f/lz/fz per operand, presents both results.
//  Sits between the FPU issue stage and the exponent/significand adders; replaces two parallel unpack instances.
// PARAMETERS
//  N       64  operand width (packed FP word; single precision lives in bits [63:32])
//  FW      53  unpacked significand width (hidden bit + 52 fraction)
//  LZW     6   leading-zero count width
//  SIG_LAT 0   pipeline latency of the shared unit in cycles (0 = combinational, sampled same cycle)
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    block can accept (IDLE only)
//  in_fa      in   N    operand A, packed
//  in_fb      in   N    operand B, packed
//  in_db      in   1    1 = double, 0 = single
//  in_unary   in   1    B unused (honoured only with UNPACK_UNARY_EN)
//  sig_fp     out  N    to shared unit: operand word
//  sig_db     out  1    to shared unit: precision
//  sig_e_z    out  1    to shared unit: exponent-is-zero
//  sig_normal out  1    to shared unit: normalise request
//  sig_f      in   FW   from shared unit: significand
//  sig_lz     in   LZW  from shared unit: leading-zero count
//  sig_fz     in   1    from shared unit: fraction zero
//  out_valid  out  1    results valid
//  out_ready  in   1    consumer accepts results
//  out_fa/out_fb     out FW   captured significands
//  out_lza/out_lzb   out LZW  captured lz counts
//  out_fza/out_fzb   out 1    captured fraction-zero flags
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  States: IDLE -> ISS_A -> ISS_B -> DONE -> IDLE.
//  IDLE: in_ready=1; on in_valid&in_ready latch in_fa/in_fb/in_db/in_unary, go ISS_A.
//  ISS_A/ISS_B: sig_* driven from latched A/B, held stable SIG_LAT+1 cycles (wait counter, width clog2(SIG_LAT+1), min 1).
//   Capture sig_f/sig_lz/sig_fz into A/B regs on the last cycle of the phase, then advance.
//  e_z: db=1 -> fp[62:52]==0; db=0 -> fp[62:55]==0. sig_normal = e_z. sig_db = latched db.
//  sig_* all 0 in IDLE and DONE.
//  DONE: out_valid=1, out_* stable; on out_ready go IDLE (in_ready=1 the following cycle, no same-cycle re-accept).
//  Latency: accept at edge T -> out_valid from cycle T+1+2*(SIG_LAT+1); SIG_LAT=0 gives T+3.
//  in_valid ignored when in_ready=0; out_ready ignored when out_valid=0.
//  Reset (any state, incl. mid-phase): next cycle state=IDLE, counter=0, out_valid=0, busy=0, all out_* and sig_* =0,
//   in_ready=0 while rst high, 1 first cycle after release; partial results discarded.
// CONFIGURATION
//  UNPACK_UNARY_EN defined: in_unary=1 skips ISS_B (ISS_A -> DONE); out_fb=0, out_lzb=0, out_fzb=1.
//  UNPACK_UNARY_EN undefined: in_unary ignored, B always issued; timing identical for all requests.
// TESTING
//  1. SIG_LAT=0, db=1, fa=0x3FF0_0000_0000_0000, fb=0x0000_0000_0000_0001 -> ISS_A e_z=0 normal=0; ISS_B e_z=1 normal=1; out_valid at T+3.
//  2. db=0, fa=0x3F80_0000_0000_0000, fb=0x0040_0000_0000_0000 -> ISS_A e_z=0; ISS_B e_z=1, normal=1; sig_db=0 both phases.
//  3. out_ready=0 for 5 cycles in DONE -> out_valid=1, out_* unchanged, in_ready=0, in_valid pulses ignored.
//  4. SIG_LAT=2 -> sig_fp holds fa 3 cycles then fb 3 cycles; out_valid at T+7; captures match model's delayed outputs.
//  5. rst=1 during ISS_B -> next cycle out_valid=0, busy=0, sig_*=0; in_ready=1 cycle after rst drops; new op completes normally.
//  6. UNPACK_UNARY_EN, in_unary=1 -> out_valid at T+2, out_fzb=1, out_fb=0; macro off -> out_valid at T+3, B captured.

Source files
------------

// File: rtl/unpack_sig_sched.sv
// Sequences one shared significand-unpack unit over operand A then operand B.
// Define UNPACK_UNARY_EN to let in_unary requests skip the B phase.
module unpack_sig_sched #(
  parameter int N       = 64,
  parameter int FW      = 53,
  parameter int LZW     = 6,
  parameter int SIG_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_fa,
  input  logic [N-1:0]   in_fb,
  input  logic           in_db,
  input  logic           in_unary,
  output logic [N-1:0]   sig_fp,
  output logic           sig_db,
  output logic           sig_e_z,
  output logic           sig_normal,
  input  logic [FW-1:0]  sig_f,
  input  logic [LZW-1:0] sig_lz,
  input  logic           sig_fz,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [FW-1:0]  out_fa,
  output logic [FW-1:0]  out_fb,
  output logic [LZW-1:0] out_lza,
  output logic [LZW-1:0] out_lzb,
  output logic           out_fza,
  output logic           out_fzb,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and payload is held while valid.

  localparam int CW = (SIG_LAT > 0) ? $clog2(SIG_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISS_A = 2'd1,
    ISS_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  fb_q;
  logic          db_q;
  logic          phase_last;
  logic          skip_b;

  // Exponent field is zero: double uses bits [62:52], single lives in the upper word.
  function automatic logic exp_zero(input logic [N-1:0] fp, input logic db);
    return db ? (fp[N-2:N-12] == '0) : (fp[N-2:N-9] == '0);
  endfunction

`ifdef UNPACK_UNARY_EN
  logic unary_q;
  assign skip_b = unary_q;
`else
  logic unused_unary;
  assign unused_unary = in_unary;
  assign skip_b       = 1'b0;
`endif

  assign phase_last = (cnt == CW'(SIG_LAT));
  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fb_q       <= '0;
      db_q       <= 1'b0;
      sig_fp     <= '0;
      sig_db     <= 1'b0;
      sig_e_z    <= 1'b0;
      sig_normal <= 1'b0;
      out_fa     <= '0;
      out_fb     <= '0;
      out_lza    <= '0;
      out_lzb    <= '0;
      out_fza    <= 1'b0;
      out_fzb    <= 1'b0;
`ifdef UNPACK_UNARY_EN
      unary_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            fb_q       <= in_fb;
            db_q       <= in_db;
`ifdef UNPACK_UNARY_EN
            unary_q    <= in_unary;
`endif
            cnt        <= '0;
            sig_fp     <= in_fa;
            sig_db     <= in_db;
            sig_e_z    <= exp_zero(in_fa, in_db);
            sig_normal <= exp_zero(in_fa, in_db);
            state      <= ISS_A;
          end
        end
        ISS_A: begin
          if (phase_last) begin
            out_fa  <= sig_f;
            out_lza <= sig_lz;
            out_fza <= sig_fz;
            cnt     <= '0;
            if (skip_b) begin
              // Unary ops report B as an all-zero fraction.
              out_fb     <= '0;
              out_lzb    <= '0;
              out_fzb    <= 1'b1;
              sig_fp     <= '0;
              sig_db     <= 1'b0;
              sig_e_z    <= 1'b0;
              sig_normal <= 1'b0;
              state      <= DONE;
            end else begin
              sig_fp     <= fb_q;
              sig_db     <= db_q;
              sig_e_z    <= exp_zero(fb_q, db_q);
              sig_normal <= exp_zero(fb_q, db_q);
              state      <= ISS_B;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ISS_B: begin
          if (phase_last) begin
            out_fb     <= sig_f;
            out_lzb    <= sig_lz;
            out_fzb    <= sig_fz;
            cnt        <= '0;
            sig_fp     <= '0;
            sig_db     <= 1'b0;
            sig_e_z    <= 1'b0;
            sig_normal <= 1'b0;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unpack_sig_sched.sv
// Directed bench for unpack_sig_sched: one instance with a combinational shared
// unit (SIG_LAT=0) and one with a two-cycle pipelined shared unit (SIG_LAT=2).
module tb_unpack_sig_sched;

  localparam int N   = 64;
  localparam int FW  = 53;
  localparam int LZW = 6;
`ifdef UNPACK_UNARY_EN
  localparam bit UNARY_EN = 1'b1;
`else
  localparam bit UNARY_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] in_fa = '0, in_fb = '0;
  logic         in_db = 1'b0, in_unary = 1'b0;
  logic         in_valid_0 = 1'b0, in_valid_1 = 1'b0;
  logic         out_ready_0 = 1'b0, out_ready_1 = 1'b0;

  logic           in_ready_0, in_ready_1, sig_db_0, sig_db_1, sig_e_z_0, sig_e_z_1;
  logic           sig_normal_0, sig_normal_1, out_valid_0, out_valid_1, busy_0, busy_1;
  logic           sig_fz_0, sig_fz_1, out_fza_0, out_fza_1, out_fzb_0, out_fzb_1;
  logic [N-1:0]   sig_fp_0, sig_fp_1;
  logic [FW-1:0]  sig_f_0, sig_f_1, out_fa_0, out_fa_1, out_fb_0, out_fb_1;
  logic [LZW-1:0] sig_lz_0, sig_lz_1, out_lza_0, out_lza_1, out_lzb_0, out_lzb_1;
  logic [1:0]     dbg_state_0, dbg_state_1;

  int   n_vec = 0;
  int   n_err = 0;
  logic sel = 1'b0;

  // Shared unpack unit stand-in: hidden bit from e_z, lz count, optional normalise.
  function automatic logic [FW+LZW:0] su(input logic [N-1:0] fp, input logic db,
                                         input logic ez, input logic normal);
    logic [FW-1:0]  f;
    logic [LZW-1:0] lz;
    logic           fz, seen;
    if (db) begin
      f  = {~ez, fp[51:0]};
      fz = (fp[51:0] == 52'd0);
    end else begin
      f  = {~ez, fp[54:32], 29'd0};
      fz = (fp[54:32] == 23'd0);
    end
    lz   = '0;
    seen = 1'b0;
    for (int i = FW - 1; i >= 0; i--) begin
      if (f[i]) seen = 1'b1;
      else if (!seen) lz = lz + 1'b1;
    end
    if (normal) f = f << lz;
    return {f, lz, fz};
  endfunction

  assign {sig_f_0, sig_lz_0, sig_fz_0} = su(sig_fp_0, sig_db_0, sig_e_z_0, sig_normal_0);

  logic [FW+LZW:0] pipe_1 = '0, pipe_2 = '0;
  always @(posedge clk) begin
    pipe_1 <= su(sig_fp_1, sig_db_1, sig_e_z_1, sig_normal_1);
    pipe_2 <= pipe_1;
  end
  assign {sig_f_1, sig_lz_1, sig_fz_1} = pipe_2;

  unpack_sig_sched #(.N(N), .FW(FW), .LZW(LZW), .SIG_LAT(0)) dut_lat0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_0), .in_ready(in_ready_0),
    .in_fa(in_fa), .in_fb(in_fb), .in_db(in_db), .in_unary(in_unary),
    .sig_fp(sig_fp_0), .sig_db(sig_db_0), .sig_e_z(sig_e_z_0), .sig_normal(sig_normal_0),
    .sig_f(sig_f_0), .sig_lz(sig_lz_0), .sig_fz(sig_fz_0),
    .out_valid(out_valid_0), .out_ready(out_ready_0),
    .out_fa(out_fa_0), .out_fb(out_fb_0), .out_lza(out_lza_0), .out_lzb(out_lzb_0),
    .out_fza(out_fza_0), .out_fzb(out_fzb_0), .busy(busy_0), .dbg_state(dbg_state_0)
  );

  unpack_sig_sched #(.N(N), .FW(FW), .LZW(LZW), .SIG_LAT(2)) dut_lat2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_fa(in_fa), .in_fb(in_fb), .in_db(in_db), .in_unary(in_unary),
    .sig_fp(sig_fp_1), .sig_db(sig_db_1), .sig_e_z(sig_e_z_1), .sig_normal(sig_normal_1),
    .sig_f(sig_f_1), .sig_lz(sig_lz_1), .sig_fz(sig_fz_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1),
    .out_fa(out_fa_1), .out_fb(out_fb_1), .out_lza(out_lza_1), .out_lzb(out_lzb_1),
    .out_fza(out_fza_1), .out_fzb(out_fzb_1), .busy(busy_1), .dbg_state(dbg_state_1)
  );

  // Observation mux: checks look at whichever instance sel points to.
  logic [63:0] o_in_ready, o_sig_fp, o_sig_db, o_sig_e_z, o_sig_normal, o_out_valid, o_busy;
  logic [63:0] o_out_fa, o_out_fb, o_out_lza, o_out_lzb, o_out_fza, o_out_fzb, o_state;
  assign o_in_ready   = 64'(sel ? in_ready_1   : in_ready_0);
  assign o_sig_fp     = 64'(sel ? sig_fp_1     : sig_fp_0);
  assign o_sig_db     = 64'(sel ? sig_db_1     : sig_db_0);
  assign o_sig_e_z    = 64'(sel ? sig_e_z_1    : sig_e_z_0);
  assign o_sig_normal = 64'(sel ? sig_normal_1 : sig_normal_0);
  assign o_out_valid  = 64'(sel ? out_valid_1  : out_valid_0);
  assign o_busy       = 64'(sel ? busy_1       : busy_0);
  assign o_out_fa     = 64'(sel ? out_fa_1     : out_fa_0);
  assign o_out_fb     = 64'(sel ? out_fb_1     : out_fb_0);
  assign o_out_lza    = 64'(sel ? out_lza_1    : out_lza_0);
  assign o_out_lzb    = 64'(sel ? out_lzb_1    : out_lzb_0);
  assign o_out_fza    = 64'(sel ? out_fza_1    : out_fza_0);
  assign o_out_fzb    = 64'(sel ? out_fzb_1    : out_fzb_0);
  assign o_state      = 64'(sel ? dbg_state_1  : dbg_state_0);

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_iv(input logic v);
    if (sel) in_valid_1 = v; else in_valid_0 = v;
  endtask

  task automatic set_or(input logic v);
    if (sel) out_ready_1 = v; else out_ready_0 = v;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"},  o_out_valid,  64'd0);
    chk({tag, "_busy"},   o_busy,       64'd0);
    chk({tag, "_sig_fp"}, o_sig_fp,     64'd0);
    chk({tag, "_sig_db"}, o_sig_db,     64'd0);
    chk({tag, "_sig_ez"}, o_sig_e_z,    64'd0);
    chk({tag, "_sig_nm"}, o_sig_normal, 64'd0);
    chk({tag, "_state"},  o_state,      64'd0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_op(input logic s, input int lat,
                        input logic [N-1:0] fa, input logic [N-1:0] fb,
                        input logic db, input logic un, input logic eza, input logic ezb,
                        input logic [FW-1:0] efa, input logic [FW-1:0] efb,
                        input logic [LZW-1:0] elza, input logic [LZW-1:0] elzb,
                        input logic efza, input logic efzb, input int stall);
    logic           skip;
    logic [FW-1:0]  xfb;
    logic [LZW-1:0] xlzb;
    logic           xfzb;
    skip = un && UNARY_EN;
    xfb  = skip ? '0 : efb;
    xlzb = skip ? '0 : elzb;
    xfzb = skip ? 1'b1 : efzb;
    sel = s;
    in_fa = fa; in_fb = fb; in_db = db; in_unary = un;
    set_iv(1'b1);
    #1 chk("accept_ready", o_in_ready, 64'd1);
    @(negedge clk);
    set_iv(1'b0);
    in_fa = ~fa; in_fb = ~fb; in_db = ~db;
    for (int i = 0; i <= lat; i++) begin
      chk("a_sig_fp", o_sig_fp,     fa);
      chk("a_sig_ez", o_sig_e_z,    64'(eza));
      chk("a_sig_nm", o_sig_normal, 64'(eza));
      chk("a_sig_db", o_sig_db,     64'(db));
      chk("a_valid",  o_out_valid,  64'd0);
      chk("a_busy",   o_busy,       64'd1);
      @(negedge clk);
    end
    if (!skip) begin
      for (int i = 0; i <= lat; i++) begin
        chk("b_sig_fp", o_sig_fp,     fb);
        chk("b_sig_ez", o_sig_e_z,    64'(ezb));
        chk("b_sig_nm", o_sig_normal, 64'(ezb));
        chk("b_sig_db", o_sig_db,     64'(db));
        chk("b_valid",  o_out_valid,  64'd0);
        @(negedge clk);
      end
    end
    chk("done_valid",  o_out_valid, 64'd1);
    chk("done_ready",  o_in_ready,  64'd0);
    chk("done_sig_fp", o_sig_fp,    64'd0);
    chk("done_sig_db", o_sig_db,    64'd0);
    for (int i = 0; i <= stall; i++) begin
      chk("out_fa",  o_out_fa,  64'(efa));
      chk("out_lza", o_out_lza, 64'(elza));
      chk("out_fza", o_out_fza, 64'(efza));
      chk("out_fb",  o_out_fb,  64'(xfb));
      chk("out_lzb", o_out_lzb, 64'(xlzb));
      chk("out_fzb", o_out_fzb, 64'(xfzb));
      if (i < stall) begin
        in_fa = 64'(i) << 60;
        set_iv(i[0]);
        @(negedge clk);
        chk("stall_valid", o_out_valid, 64'd1);
        chk("stall_ready", o_in_ready,  64'd0);
      end
    end
    set_iv(1'b0);
    set_or(1'b1);
    @(negedge clk);
    set_or(1'b0);
    chk("ret_valid", o_out_valid, 64'd0);
    chk("ret_ready", o_in_ready,  64'd1);
    chk("ret_busy",  o_busy,      64'd0);
  endtask

  // ---------------- directed steps ----------------
  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      chk("rst_ready", o_in_ready, 64'd0);
      chk_idle_outputs("rst");
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      chk("rel_ready", o_in_ready, 64'd1);
    end

    // double: A normal, B subnormal
    run_op(1'b0, 0, 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 1'b0,
           1'b0, 1'b1, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000,
           6'd0, 6'd52, 1'b1, 1'b0, 0);

    // single in the upper word, held 5 cycles in DONE
    run_op(1'b0, 0, 64'h3F80_0000_0000_0000, 64'h0040_0000_0000_0000, 1'b0, 1'b0,
           1'b0, 1'b1, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000,
           6'd0, 6'd1, 1'b1, 1'b0, 5);

    // pipelined shared unit, three cycles per phase
    run_op(1'b1, 2, 64'h4008_0000_0000_0000, 64'h0000_0000_0000_00F0, 1'b1, 1'b0,
           1'b0, 1'b1, 53'h18_0000_0000_0000, 53'h1E_0000_0000_0000,
           6'd0, 6'd45, 1'b0, 1'b0, 2);

    // reset while issuing B discards the partial result
    sel = 1'b0;
    in_fa = 64'h4008_0000_0000_0000; in_fb = 64'h0000_0000_0000_00F0;
    in_db = 1'b1; in_unary = 1'b0;
    set_iv(1'b1);
    @(negedge clk);
    set_iv(1'b0);
    @(negedge clk);
    chk("pre_rst_sig_fp", o_sig_fp, 64'h0000_0000_0000_00F0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", o_in_ready, 64'd0);
    chk_idle_outputs("mid_rst");
    chk("mid_rst_out_fa",  o_out_fa,  64'd0);
    chk("mid_rst_out_fza", o_out_fza, 64'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", o_in_ready, 64'd1);
    @(negedge clk);
    run_op(1'b0, 0, 64'h3F80_0000_0000_0000, 64'h0040_0000_0000_0000, 1'b0, 1'b0,
           1'b0, 1'b1, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000,
           6'd0, 6'd1, 1'b1, 1'b0, 0);

    // unary request: B skipped only when the feature is built in
    run_op(1'b0, 0, 64'h4008_0000_0000_0000, 64'h0000_0000_0000_00F0, 1'b1, 1'b1,
           1'b0, 1'b1, 53'h18_0000_0000_0000, 53'h1E_0000_0000_0000,
           6'd0, 6'd45, 1'b0, 1'b0, 0);
    run_op(1'b1, 2, 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 1'b1,
           1'b0, 1'b1, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000,
           6'd0, 6'd52, 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
